// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing/image path.
//
// Samples hsync/vsync (active low) and 12-bit RGB on the pixel clock, rebuilds
// the h/v counters from the sync edges, checks line and frame geometry
// against the configured timing and declares lock after LOCK_FRAMES
// consecutive good frames.
//
// Ports:
//   clk_25_175     in   pixel clock
//   rst            in   asynchronous, active-high reset
//   hsync, vsync   in   syncs, active low
//   r, g, b        in   4-bit colour components
//   pixel_valid    out  registered strobe for a visible pixel while locked
//   pixel_x/y      out  visible column/row of the strobed pixel
//   pixel_rgb      out  {r,g,b} of the strobed pixel
//   locked         out  geometry lock
//   frame_done     out  one-cycle pulse one cycle after each frame anchor
//   frame_ok       out  geometry verdict of the completed frame
//   frame_checksum out  16-bit sum of visible samples of the completed frame
module vga_capture #(
    parameter int H_FRONT     = 16,
    parameter int H_VISIBLE   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_FRONT     = 10,
    parameter int V_VISIBLE   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25_175,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [11:0] pixel_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_checksum
);

    localparam int H_TOTAL = H_FRONT + H_VISIBLE + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_FRONT + V_VISIBLE + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_LO = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_VIS_HI = HW'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LO = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_VIS_HI = VW'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs_prev_q, hs_prev_d;
    logic          vs_prev_q, vs_prev_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          armed_q, armed_d;
    logic          frame_bad_q, frame_bad_d;
    logic [15:0]   acc_q, acc_d;
    logic [3:0]    good_q, good_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [9:0]    pixel_x_q, pixel_x_d;
    logic [8:0]    pixel_y_q, pixel_y_d;
    logic [11:0]   pixel_rgb_q, pixel_rgb_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic [15:0]   frame_checksum_q, frame_checksum_d;

    logic          h_edge, v_fall, anchor;
    logic          line_bad, timeout, v_sat, frame_good, visible;
    logic [15:0]   acc_sum;

    always_comb begin
        hs_prev_d = hsync;
        vs_prev_d = vsync;
        h_edge    = ~hsync & hs_prev_q;
        v_fall    = ~vsync & vs_prev_q;
        // A vsync fall arms the anchor; the anchor itself is the next hsync
        // edge, which may be the same cycle as the vsync fall.
        anchor    = h_edge & (armed_q | v_fall);

        armed_d = armed_q;
        if (anchor)      armed_d = 1'b0;
        else if (v_fall) armed_d = 1'b1;

        if (h_edge)               h_cnt_d = '0;
        else if (h_cnt_q == H_MAX) h_cnt_d = H_MAX;
        else                      h_cnt_d = h_cnt_q + HW'(1);

        line_bad = h_edge & (h_cnt_q != H_LAST);
        // Saturation stops the count at H_MAX, so this fires once per lost line.
        timeout  = ~h_edge & (h_cnt_q == H_LAST);

        v_cnt_d = v_cnt_q;
        if (anchor)                         v_cnt_d = '0;
        else if (h_edge && v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + VW'(1);
        v_sat = h_edge & ~anchor & (v_cnt_q == V_LAST);

        // The line ending at the anchor belongs to the frame being completed.
        frame_good  = ~frame_bad_q & ~line_bad & (v_cnt_q == V_LAST);
        frame_bad_d = anchor ? 1'b0 : (frame_bad_q | line_bad | timeout | v_sat);

        // Window is judged on the counts this sample carries (post-update).
        visible = (h_cnt_d >= H_VIS_LO) && (h_cnt_d < H_VIS_HI) &&
                  (v_cnt_d >= V_VIS_LO) && (v_cnt_d < V_VIS_HI);
        acc_sum = acc_q + (visible ? {4'b0000, r, g, b} : 16'h0000);
        acc_d   = anchor ? 16'h0000 : acc_sum;

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (anchor) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (anchor) begin
                    if (frame_good) begin
                        good_d = good_q + 4'd1;
                        if (good_d == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad | timeout | v_sat | (anchor & ~frame_good)) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase

        // Strobe only if lock holds both before and after this sample, so a
        // sample on the detection cycle is never strobed.
        pixel_valid_d = visible & (state_q == LOCKED) & (state_d == LOCKED);
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_rgb_d   = pixel_rgb_q;
        if (pixel_valid_d) begin
            pixel_x_d   = 10'(h_cnt_d - H_VIS_LO);
            pixel_y_d   = 9'(v_cnt_d - V_VIS_LO);
            pixel_rgb_d = {r, g, b};
        end

        frame_done_d     = anchor & (state_q != SEARCH);
        frame_ok_d       = frame_ok_q;
        frame_checksum_d = frame_checksum_q;
        if (frame_done_d) begin
            frame_ok_d       = frame_good;
            frame_checksum_d = acc_sum;
        end
    end

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            state_q          <= SEARCH;
            hs_prev_q        <= 1'b1;
            vs_prev_q        <= 1'b1;
            h_cnt_q          <= '0;
            v_cnt_q          <= '0;
            armed_q          <= 1'b0;
            frame_bad_q      <= 1'b0;
            acc_q            <= '0;
            good_q           <= '0;
            pixel_valid_q    <= 1'b0;
            pixel_x_q        <= '0;
            pixel_y_q        <= '0;
            pixel_rgb_q      <= '0;
            frame_done_q     <= 1'b0;
            frame_ok_q       <= 1'b0;
            frame_checksum_q <= '0;
        end else begin
            state_q          <= state_d;
            hs_prev_q        <= hs_prev_d;
            vs_prev_q        <= vs_prev_d;
            h_cnt_q          <= h_cnt_d;
            v_cnt_q          <= v_cnt_d;
            armed_q          <= armed_d;
            frame_bad_q      <= frame_bad_d;
            acc_q            <= acc_d;
            good_q           <= good_d;
            pixel_valid_q    <= pixel_valid_d;
            pixel_x_q        <= pixel_x_d;
            pixel_y_q        <= pixel_y_d;
            pixel_rgb_q      <= pixel_rgb_d;
            frame_done_q     <= frame_done_d;
            frame_ok_q       <= frame_ok_d;
            frame_checksum_q <= frame_checksum_d;
        end
    end

    assign pixel_valid    = pixel_valid_q;
    assign pixel_x        = pixel_x_q;
    assign pixel_y        = pixel_y_q;
    assign pixel_rgb      = pixel_rgb_q;
    assign locked         = (state_q == LOCKED);
    assign frame_done     = frame_done_q;
    assign frame_ok       = frame_ok_q;
    assign frame_checksum = frame_checksum_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 15x10 raster so that many frames fit in
// a short run. The generator knows each sample's line/column position, and the
// reference model reasons in frames and lines: a frame is good when all its
// lines are HT long and it has VT lines; any defect drops lock and restarts
// the good-frame run.
module tb_vga_capture;
    localparam int HF = 2, HV = 8, HS = 3, HB = 2;
    localparam int VF = 1, VV = 6, VS = 1, VB = 2;
    localparam int LF = 2;
    localparam int HT = HF + HV + HS + HB;   // 15
    localparam int VT = VF + VV + VS + VB;   // 10

    logic        clk;
    logic        rst;
    logic        hsync, vsync;
    logic [3:0]  r, g, b;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [11:0] pixel_rgb;
    logic        locked, frame_done, frame_ok;
    logic [15:0] frame_checksum;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          exp_locked, synced, frame_bad, exp_ok, lock_all, const_rgb, seen_lock;
    int          run, nlines, prev_len, strobe_cnt, anchor_cnt, first_lock_anchor;
    logic [15:0] frame_sum, exp_sum;

    vga_capture #(
        .H_FRONT(HF), .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_25_175(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_rgb(pixel_rgb), .locked(locked), .frame_done(frame_done),
        .frame_ok(frame_ok), .frame_checksum(frame_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_x"}, 32'(pixel_x), 32'd0);
        chk({tag, "_y"}, 32'(pixel_y), 32'd0);
        chk({tag, "_rgb"}, 32'(pixel_rgb), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_ok"}, 32'(frame_ok), 32'd0);
        chk({tag, "_sum"}, 32'(frame_checksum), 32'd0);
    endtask

    task automatic model_reset();
        exp_locked = 0; synced = 0; frame_bad = 0; exp_ok = 0;
        run = 0; nlines = 0; prev_len = HT;
        frame_sum = '0; exp_sum = '0;
    endtask

    task automatic drop_lock();
        exp_locked = 0;
        run = 0;
    endtask

    // Drive one line of len samples at frame row y and check every output.
    task automatic send_line(input int y, input int len);
        for (int c = 0; c < len; c++) begin
            logic [11:0] rgb;
            bit vis, lk0, exp_done, exp_pv;
            rgb = const_rgb ? 12'h001 : 12'($urandom);
            hsync = (c >= HS);
            vsync = (y >= VS);
            {r, g, b} = rgb;
            lk0 = exp_locked;
            exp_done = 0;
            if (c == 0) begin
                if (prev_len != HT) frame_bad = 1;
                if (y == 0) begin
                    anchor_cnt++;
                    if (synced) begin
                        exp_done = 1;
                        exp_ok   = !frame_bad && (nlines == VT);
                        exp_sum  = frame_sum;
                        if (exp_ok) begin
                            if (!exp_locked) begin
                                run++;
                                if (run == LF) exp_locked = 1;
                            end
                        end else begin
                            drop_lock();
                        end
                    end else begin
                        synced = 1;
                        run = 0;
                    end
                    frame_bad = 0;
                    nlines    = 0;
                    frame_sum = '0;
                end else begin
                    if (prev_len != HT) drop_lock();
                    if (y == VT) begin
                        frame_bad = 1;
                        drop_lock();
                    end
                end
                nlines++;
            end
            if (c == HT) begin
                frame_bad = 1;
                drop_lock();
            end
            vis = (c >= HS + HB) && (c < HS + HB + HV) && (y >= VS + VB) && (y < VS + VB + VV);
            if (vis) frame_sum = frame_sum + 16'(rgb);
            exp_pv = vis && lk0 && exp_locked;
            lock_all = lock_all && exp_locked;

            @(posedge clk);
            #1;
            chk("locked", 32'(locked), 32'(exp_locked));
            chk("pixel_valid", 32'(pixel_valid), 32'(exp_pv));
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("frame_ok", 32'(frame_ok), 32'(exp_ok));
            chk("frame_checksum", 32'(frame_checksum), 32'(exp_sum));
            if (exp_pv) begin
                chk("pixel_x", 32'(pixel_x), 32'(c - (HS + HB)));
                chk("pixel_y", 32'(pixel_y), 32'(y - (VS + VB)));
                chk("pixel_rgb", 32'(pixel_rgb), 32'(rgb));
            end
            if (pixel_valid) strobe_cnt++;
            if (!seen_lock && locked) begin
                seen_lock = 1;
                first_lock_anchor = (y == 0 && c == 0) ? anchor_cnt : -1;
            end
        end
        prev_len = len;
    endtask

    // One frame of nl lines; row bad_y (if any) gets length bad_len.
    task automatic send_frame(input int nl, input int bad_y, input int bad_len);
        strobe_cnt = 0;
        lock_all = 1;
        for (int y = 0; y < nl; y++)
            send_line(y, (y == bad_y) ? bad_len : HT);
        if (lock_all) chk("strobes_per_frame", 32'(strobe_cnt), 32'(HV * VV));
    endtask

    task automatic reset_mid_line();
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            {r, g, b} = 12'($urandom);
            @(posedge clk);
            #1;
            chk_all_zero("rst_hold");
        end
        hsync = 1'b1;
        vsync = 1'b1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; hsync = 1'b1; vsync = 1'b1; {r, g, b} = 12'h000;
        model_reset();
        anchor_cnt = 0; seen_lock = 0; first_lock_anchor = 0; const_rgb = 1;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // ideal timing, constant colour: lock one cycle after the 3rd anchor
        for (int f = 0; f < 4; f++) send_frame(VT, -1, 0);
        chk("lock_anchor", 32'(first_lock_anchor), 32'(LF + 1));
        send_frame(VT, -1, 0);
        chk("ideal_checksum", 32'(frame_checksum), 32'(HV * VV));
        chk("ideal_ok", 32'(frame_ok), 32'd1);
        const_rgb = 0;

        // short line while locked, then re-lock
        send_frame(VT, 5, HT - 1);
        chk("short_locked", 32'(locked), 32'd0);
        for (int f = 0; f < 3; f++) send_frame(VT, -1, 0);
        chk("short_frame_relock", 32'(locked), 32'd1);

        // one extra line: drop at saturation, bad verdict at the next anchor
        send_frame(VT + 1, -1, 0);
        chk("long_frame_locked", 32'(locked), 32'd0);
        send_frame(VT, -1, 0);
        chk("long_frame_ok", 32'(frame_ok), 32'd0);
        for (int f = 0; f < 2; f++) send_frame(VT, -1, 0);
        chk("long_frame_relock", 32'(locked), 32'd1);

        // hsync stuck high for a line: timeout
        send_frame(VT, 4, HT + 10);
        chk("lost_sync_locked", 32'(locked), 32'd0);
        for (int f = 0; f < 3; f++) send_frame(VT, -1, 0);

        // randomized mix of clean and defective frames
        for (int f = 0; f < 12; f++) begin
            int kind;
            kind = int'($urandom_range(0, 6));
            case (kind)
                0: send_frame(VT, int'($urandom_range(0, VT - 1)), int'($urandom_range(HT - 5, HT - 1)));
                1: send_frame(VT, int'($urandom_range(0, VT - 1)), int'($urandom_range(HT + 1, HT + 10)));
                2: send_frame(VT + 1, -1, 0);
                3: send_frame(VT - 1, -1, 0);
                default: send_frame(VT, -1, 0);
            endcase
        end
        for (int f = 0; f < 3; f++) send_frame(VT, -1, 0);
        chk("random_relock", 32'(locked), 32'd1);

        // reset in the middle of a line, then a fresh lock
        for (int y = 0; y < 4; y++) send_line(y, HT);
        send_line(4, 7);
        reset_mid_line();
        for (int f = 0; f < 4; f++) send_frame(VT, -1, 0);
        chk("post_reset_lock", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
